nn_instr_issuer: RTL
====================

// Module: nn_instr_issuer
// PURPOSE
//  Producer side of the 38-bit nn instruction bus. The block buffers host commands in a FIFO and
//  replays them onto `instruction`, cycle-timed for the control unit. Each command is held for a
//  programmed number of cycles, followed by NOP gap cycles. Sits between the host/testbench and nn.
// PARAMETERS
//  DEPTH       8   command FIFO entries; power of two, >=2
//  HOLD_W      8   width of the per-command hold count
//  GAP_CYCLES  1   NOP (all-zero) cycles inserted after each instruction; 0 = back-to-back
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 reset, asynchronous, active-low (0 = reset)
//  cmd_valid    in   1                 host offers a command
//  cmd_ready    out  1                 FIFO can accept: !full && !flush
//  cmd_instr    in   38                instruction word to issue
//  cmd_hold     in   HOLD_W            extra cycles to hold; word is driven cmd_hold+1 cycles
//  run          in   1                 1 = issuer may pop the FIFO
//  flush        in   1                 sync: empty FIFO, abort current word
//  instruction  out  38                registered word to nn control unit
//  busy         out  1                 FSM not IDLE
//  done         out  1                 1-cycle pulse: sequence finished, FIFO empty
//  fifo_count   out  $clog2(DEPTH)+1   entries stored
//  cmd_err      out  1                 sticky illegal-command flag (ISSUER_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  Word layout (issued verbatim):
//   [15:0]  input data
//   [17:16] address
//   [18]    load_bias
//   [19]    load_weights
//   [20]    load_inputs
//   [21]    nn_start
//   [23:22] activation_datapath
//   [37:24] reserved, 0
//  Reset (rst=0): FIFO empty, FSM IDLE.
//   Outputs: instruction=0, busy=0, done=0, fifo_count=0, cmd_err=0; cmd_ready=1 once rst=1.
//  Push: cmd_valid&&cmd_ready at an edge writes {cmd_instr,cmd_hold} at the tail.
//   Push and pop in the same cycle are both honoured.
//   Full: cmd_ready=0; offered data is ignored and must be held by the host.
//  FSM states:
//   IDLE: instruction=0.
//    If run && !empty: pop the head, load the word into the output register, hold_cnt=cmd_hold -> HOLD.
//   HOLD: word stable on instruction.
//    hold_cnt>0: decrement.
//    hold_cnt==0 and GAP_CYCLES>0: instruction<=0, gap_cnt=GAP_CYCLES-1 -> GAP.
//    hold_cnt==0 and GAP_CYCLES==0: if run && !empty, pop the next word directly (no bubble) -> HOLD;
//     else instruction<=0 -> IDLE.
//   GAP: instruction=0; gap_cnt counts down.
//    At 0: if run && !empty, pop -> HOLD; else -> IDLE.
//  Latency: a push accepted at edge k into an empty FIFO, in IDLE with run=1, is popped at edge k+1.
//   The word is visible on instruction from edge k+1 for exactly cmd_hold+1 cycles.
//  done: asserts for 1 cycle on the edge that enters IDLE from HOLD/GAP while the FIFO is empty.
//   No pulse if exit was caused by run=0 with entries remaining, or by flush.
//  run=0 mid-sequence: the current HOLD/GAP completes; no further pop; -> IDLE.
//  flush=1: at the next edge the FIFO is emptied, instruction<=0, FSM -> IDLE, no done.
//   Flush overrides push and pop in the same cycle.
//  hold_cnt and gap_cnt are unsigned and never wrap; the FIFO pointers wrap modulo DEPTH.
//  fifo_count = entries stored, 0..DEPTH.
// CONFIGURATION
//  ISSUER_CHECK_EN defined: at push, a word is illegal if any of these hold:
//   - more than one of bits [20:18] is set
//   - address == 2'b11
//   - any reserved bit is set
//  An illegal word is accepted (handshake completes) but discarded, and cmd_err is set.
//  cmd_err stays set until rst or flush.
//  Macro undefined: every word is stored verbatim; cmd_err is tied to 0.
// TESTING
//  1 Reset mid-HOLD (rst=0 for 1 cycle) -> instruction=0, fifo_count=0, busy=0 immediately (asynchronous).
//  2 One push instr=38'h0000_30_0005, hold=2, GAP=1, run=1
//    -> word on instruction for exactly 3 cycles, then 1 zero cycle, then done pulse and busy=0.
//  3 Fill DEPTH=8 with run=0 -> cmd_ready=0 and fifo_count=8.
//    Then run=1 -> 8 words issued in order; cmd_ready rises the cycle after the first pop.
//  4 GAP_CYCLES=0, two pushes (hold=0) -> words appear on consecutive cycles with no zero bubble.
//  5 flush during HOLD of the 2nd of 4 words -> instruction=0 next cycle, fifo_count=0, no done pulse.
//  6 ISSUER_CHECK_EN: push word with bits 19 and 20 set -> fifo_count unchanged, cmd_err=1;
//    next legal word still issues.

Source files
------------

// File: rtl/nn_instr_issuer.sv
// Command FIFO plus IDLE/HOLD/GAP sequencer that replays host words onto the 38-bit nn instruction bus.
// Optional build macro ISSUER_CHECK_EN enables push-time legality checking and the sticky cmd_err flag.
module nn_instr_issuer #(
  parameter int DEPTH      = 8,
  parameter int HOLD_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [37:0]              cmd_instr,
  input  logic [HOLD_W-1:0]        cmd_hold,
  input  logic                     run,
  input  logic                     flush,
  output logic [37:0]              instruction,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     cmd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 38 + HOLD_W;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [37:0]       instr_q, instr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              done_q, done_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic              empty, full, push_acc, push_wr, pop, can_pop, illegal;
  logic [EW-1:0]     head;
  logic [37:0]       head_instr;
  logic [HOLD_W-1:0] head_hold;

`ifdef ISSUER_CHECK_EN
  logic err_q, err_d;

  // Illegal: more than one load strobe, address 3, or any reserved bit set.
  function automatic logic bad_word(input logic [37:0] w);
    logic multi_load;
    multi_load = (w[18] & w[19]) | (w[18] & w[20]) | (w[19] & w[20]);
    return multi_load | (w[17:16] == 2'b11) | (|w[37:24]);
  endfunction

  assign illegal = bad_word(cmd_instr);
  assign err_d   = flush ? 1'b0 : (err_q | (push_acc & illegal));
  assign cmd_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  assign illegal = 1'b0;
  assign cmd_err = 1'b0;
`endif

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign cmd_ready  = !full && !flush;
  assign push_acc   = cmd_valid && cmd_ready;
  assign push_wr    = push_acc && !illegal;
  assign can_pop    = run && !empty;
  assign head       = mem_q[rd_ptr_q];
  assign head_instr = head[EW-1:HOLD_W];
  assign head_hold  = head[HOLD_W-1:0];

  // Storage holds data only; occupancy is tracked by the reset pointers/count.
  always_ff @(posedge clk) begin
    if (push_wr) mem_q[wr_ptr_q] <= {cmd_instr, cmd_hold};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_wr);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push_wr) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      instr_d = '0;
      hold_d  = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_d = '0;
          if (can_pop) begin
            pop     = 1'b1;
            instr_d = head_instr;
            hold_d  = head_hold;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (GAP_CYCLES > 0) begin
            instr_d = '0;
            gap_d   = GAP_INIT;
            state_d = S_GAP;
          end else if (can_pop) begin
            pop     = 1'b1;
            instr_d = head_instr;
            hold_d  = head_hold;
          end else begin
            instr_d = '0;
            state_d = S_IDLE;
            done_d  = empty;
          end
        end
        S_GAP: begin
          instr_d = '0;
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else if (can_pop) begin
            pop     = 1'b1;
            instr_d = head_instr;
            hold_d  = head_hold;
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
            done_d  = empty;
          end
        end
        default: begin
          state_d = S_IDLE;
          instr_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      hold_q   <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign instruction = instr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign fifo_count  = count_q;

endmodule
